// File: rtl/mca_mult_seq.sv
// Sequential 4x4 approximate multiplier: one 4-bit maskable-carry adder reused
// over four shift-add steps, with valid/ready handshakes on operands and product.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one shift-add step per cycle, cnt 0..3
// DONE  | product valid, held until out_ready
module mca_mult_seq #(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] mask,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] product,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_a;
  logic [3:0]  r_mask;
  logic [3:0]  r_h;
  logic [3:0]  r_l;
  logic [1:0]  r_cnt;
  logic [7:0]  r_product;

  logic [3:0]  w_sum;
  logic [4:0]  w_carry;
  logic [3:0]  w_h_step;
  logic        w_c_step;
  logic        w_skip;

  // Ripple adder whose carry into each next bit can be killed by the mask.
  always_comb begin
    w_sum      = '0;
    w_carry    = '0;
    w_carry[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_sum[i]     = r_h[i] ^ r_a[i] ^ w_carry[i];
      w_carry[i+1] = ((r_h[i] & r_a[i]) | ((r_h[i] ^ r_a[i]) & w_carry[i])) & ~r_mask[i];
    end
  end

  assign w_c_step = r_l[0] & w_carry[4];
  assign w_h_step = r_l[0] ? w_sum : r_h;
  assign w_skip   = SKIP_ZERO && ((a == 4'd0) || (b == 4'd0));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = w_skip ? DONE : RUN;
      RUN:     if (r_cnt == 2'd3) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_mask    <= '0;
      r_h       <= '0;
      r_l       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a    <= a;
            r_mask <= mask;
            r_h    <= '0;
            r_l    <= w_skip ? 4'd0 : b;
            r_cnt  <= '0;
            if (w_skip) r_product <= '0;
          end
        end
        RUN: begin
          // {C,H,L} >> 1 with the adder carry entering H[3]
          r_h   <= {w_c_step, w_h_step[3:1]};
          r_l   <= {w_h_step[0], r_l[3:1]};
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) r_product <= {w_c_step, w_h_step[3:1], w_h_step[0], r_l[3:1]};
        end
        default: ;
      endcase
    end
  end

  // in_ready is gated by rst_n so it reads low for as long as reset is held.
  assign in_ready  = (r_state == IDLE) && rst_n;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN);
  assign product   = r_product;

endmodule

// File: doc/mca_mult_seq.md
# mca_mult_seq

Sequential 4x4 approximate multiplier controller. It time-shares one 4-bit maskable-carry adder over four shift-add steps to form an 8-bit product. A per-operation carry mask sets the approximation level: mask 0000 gives an exact product, mask 1111 gives a carry-less product. It sits between the operand source and the result consumer of the approximate-multiplier datapath, using a valid/ready handshake on both sides.

## Interface
Parameters:
- SKIP_ZERO, default 0: when 1, an operation with a zero operand bypasses the add loop.

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand request
- in_ready  output  1  high only in IDLE
- a  input  4  multiplicand, sampled on accept
- b  input  4  multiplier, sampled on accept
- mask  input  4  carry-kill mask, sampled on accept
- out_valid  output  1  product valid, high only in DONE
- out_ready  input  1  consumer accepts product
- product  output  8  result, registered
- busy  output  1  high in RUN

## Operation
- Adder function, shared by all steps, with c0 = 0 and bit i = 0..3:
  - s_i = x_i ^ y_i ^ c_i
  - c_{i+1} = ((x_i & y_i) | ((x_i ^ y_i) & c_i)) & ~mask_r[i]
  - cout = c4
- Registers: A_r[3:0], mask_r[3:0], H[3:0], L[3:0], C (1 bit), cnt[1:0], state.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: load A_r = a, mask_r = mask, L = b, H = 0, C = 0, cnt = 0, then go to RUN.
  - If SKIP_ZERO = 1 and (a == 0 or b == 0): set H = 0 and L = 0 and go directly to DONE.
- RUN, one step per cycle:
  - If L[0] = 1: {C, H} = adder(H, A_r); otherwise {C, H} = {0, H}.
  - Then {C, H, L} shifts right by 1, with C filling H[3].
  - cnt increments. The step at cnt = 3 goes to DONE and loads product = {H, L} post-shift.
- DONE:
  - out_valid = 1 and product is held stable until out_ready.
  - On out_ready, go to IDLE. out_valid drops and in_ready rises on the next cycle.
- No overlap: no new operand is accepted while in RUN or DONE. in_valid is ignored there.
- Inputs a, b and mask may change freely after accept. Only the latched copies are used.
- With mask_r = 0000 the product is exact.
- Carries killed by mask never reach C, so the product is always 8 bits and never overflows.

## Timing
- Reset (rst_n low at a rising edge):
  - state = IDLE; product = 0x00; out_valid = 0; busy = 0.
  - In the cycle after that edge, in_ready = 1.
  - While rst_n is held low, in_ready = 0.
- Reset in RUN or DONE aborts the operation and discards any partial product, with the same values as above.
- Accept happens at the edge where in_valid & in_ready. busy is high starting the next cycle.
- Normal latency: out_valid rises 4 cycles after the accept edge. busy is high for exactly 4 cycles.
- Skip latency (SKIP_ZERO = 1, zero operand): out_valid rises 1 cycle after the accept edge with product 0x00. busy stays 0.
- Back-pressure: out_valid stays high with product stable for any number of cycles until out_ready.
  - If out_ready is already high when out_valid rises, the transfer completes at the next edge.
  - Minimum turnaround is 6 cycles from one accept to the next.
- out_ready is ignored outside DONE.
- All outputs are registered or decoded from state only. There is no combinational input-to-output path.

## Test plan
- Exact multiply: a = 13, b = 11, mask = 0000. Require product 0x8F with out_valid 4 cycles after accept. Also a = 15, b = 15, mask = 0000, requiring 0xE1.
- Carry-less multiply: a = 15, b = 15, mask = 1111 gives 0x55. a = 13, b = 11, mask = 1111 gives 0x7F.
- Exhaustive: all 256 operand pairs with mask = 0000 must match a*b. Then compare all operands × all 16 masks against a bit-accurate model of the masked adder.
- Back-pressure and handshake:
  - Hold out_ready = 0 for 10 cycles. Product must stay stable and in_ready must stay 0.
  - A new in_valid during RUN or DONE must be ignored. Change a, b and mask after accept; the result must be unchanged.
- Zero operand: a = 0, b = 9.
  - SKIP_ZERO = 0: product 0x00 after 4 cycles, busy high.
  - SKIP_ZERO = 1: product 0x00 after 1 cycle, busy never high.
- Reset mid-operation: assert rst_n = 0 during RUN cnt = 2. Next cycle requires out_valid = 0, busy = 0, product = 0x00. After release, in_ready = 1, and a fresh 13×11 operation yields 0x8F.
